// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// memory-wait holds with a timeout, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int ARQ         = 16,
    parameter int LU_STALL    = 1,
    parameter int FLUSH_CYC   = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     id_src1_idx,
    input  logic [3:0]     id_src2_idx,
    input  logic           id_src1_used,
    input  logic           id_src2_used,
    input  logic [3:0]     exe_dest_idx,
    input  logic           exe_rd_mem_en,
    input  logic           exe_wb_en,
    input  logic           branch_taken,
    input  logic           mem_req,
    input  logic           mem_ready,
    output logic           pc_en,
    output logic           ifid_stop,
    output logic           ifid_flush,
    output logic           idexe_bubble,
    output logic           exemem_hold,
    output logic [1:0]     state,
    output logic [ARQ-1:0] stall_cycles,
    output logic           mem_timeout_err
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    localparam logic [7:0] LU_C1 = 8'(LU_STALL - 1);
    localparam logic [7:0] FL_C  = 8'(FLUSH_CYC);
    localparam logic [7:0] FL_C1 = 8'(FLUSH_CYC - 1);
    localparam logic [7:0] MT_C1 = 8'(MEM_TIMEOUT - 1);

    state_t         state_r, state_n;
    logic [7:0]     cnt_r, cnt_n;
    logic           pend_r, pend_n;
    logic           err_r, err_set_s;
    logic [ARQ-1:0] stall_r;
    logic           mw_s, lu_s;
    logic           pc_s, stop_s, flush_s, bub_s, hold_s;

    assign mw_s = mem_req & ~mem_ready;
    assign lu_s = exe_rd_mem_en & exe_wb_en &
                  ((id_src1_used & (id_src1_idx == exe_dest_idx)) |
                   (id_src2_used & (id_src2_idx == exe_dest_idx)));

    // Next-state, counter and Mealy control outputs with MW > branch > LU priority
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        pend_n    = pend_r;
        err_set_s = 1'b0;
        pc_s      = 1'b1;
        stop_s    = 1'b0;
        flush_s   = 1'b0;
        bub_s     = 1'b0;
        hold_s    = 1'b0;
        case (state_r)
            MEM_WAIT: begin
                // Completion and timeout share the same exit path
                if (mem_ready || (cnt_r <= 8'd1)) begin
                    pend_n = 1'b0;
                    if (pend_r || branch_taken) begin
                        state_n = FLUSH;
                        cnt_n   = FL_C;
                    end else begin
                        state_n = RUN;
                        cnt_n   = 8'd0;
                    end
                end else begin
                    cnt_n  = cnt_r - 8'd1;
                    pend_n = pend_r | branch_taken;
                end
                if (mem_ready) begin
                    err_set_s = 1'b0;
                end else begin
                    pc_s      = 1'b0;
                    stop_s    = 1'b1;
                    hold_s    = 1'b1;
                    err_set_s = (cnt_r <= 8'd1);
                end
            end
            default: begin
                if (mw_s) begin
                    pc_s    = 1'b0;
                    stop_s  = 1'b1;
                    hold_s  = 1'b1;
                    state_n = MEM_WAIT;
                    cnt_n   = MT_C1;
                    pend_n  = branch_taken;
                end else if (branch_taken) begin
                    flush_s = 1'b1;
                    bub_s   = (state_r != FLUSH);
                    if (FLUSH_CYC > 1) begin
                        state_n = FLUSH;
                        cnt_n   = FL_C1;
                    end else begin
                        state_n = RUN;
                        cnt_n   = 8'd0;
                    end
                end else if (state_r == FLUSH) begin
                    flush_s = 1'b1;
                    if (cnt_r <= 8'd1) begin
                        state_n = RUN;
                        cnt_n   = 8'd0;
                    end else begin
                        cnt_n = cnt_r - 8'd1;
                    end
                end else if (state_r == LOAD_STALL) begin
                    pc_s   = 1'b0;
                    stop_s = 1'b1;
                    bub_s  = 1'b1;
                    if (cnt_r <= 8'd1) begin
                        state_n = RUN;
                        cnt_n   = 8'd0;
                    end else begin
                        cnt_n = cnt_r - 8'd1;
                    end
                end else if (lu_s) begin
                    pc_s   = 1'b0;
                    stop_s = 1'b1;
                    bub_s  = 1'b1;
                    if (LU_STALL > 1) begin
                        state_n = LOAD_STALL;
                        cnt_n   = LU_C1;
                    end else begin
                        state_n = RUN;
                        cnt_n   = 8'd0;
                    end
                end else begin
                    state_n = RUN;
                end
            end
        endcase
    end

    // State, counters and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= 8'd0;
            pend_r  <= 1'b0;
            err_r   <= 1'b0;
            stall_r <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            pend_r  <= pend_n;
            if (err_set_s) begin
                err_r <= 1'b1;
            end
            if (!pc_s && (stall_r != {ARQ{1'b1}})) begin
                stall_r <= stall_r + ARQ'(1);
            end
        end
    end

    // Reset forces a quiet, running pipeline without waiting for a clock edge
    assign pc_en           = pc_s | rst;
    assign ifid_stop       = stop_s & ~rst;
    assign ifid_flush      = flush_s & ~rst;
    assign idexe_bubble    = bub_s & ~rst;
    assign exemem_hold     = hold_s & ~rst;
    assign state           = state_r;
    assign stall_cycles    = stall_r;
    assign mem_timeout_err = err_r;

endmodule
